// File: rtl/dmem_dump_ctrl.sv
// dmem_dump_ctrl
// Freezes the processor, lets in-flight writes settle, then streams every
// data-memory word out as a valid/ready beat (word index + value).
//
// state | meaning
// IDLE  | waiting for a rising edge on i_dump
// DRAIN | CPU stalled, waiting for pipeline writes to settle
// READ  | one-cycle memory read of word idx
// CAPT  | read data and index latched into the beat registers
// SEND  | beat offered until i_dump_ready accepts it
// DONE  | one-cycle completion pulse, then back to IDLE
module dmem_dump_ctrl #(
    parameter int N         = 64,
    parameter int ADDR_W    = 6,
    parameter int NWORDS    = 64,
    parameter int DRAIN_CYC = 5
) (
    input  logic              i_mclk,
    input  logic              i_reset,
    input  logic              i_dump,
    output logic              o_cpu_stall,
    output logic              o_mem_re,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [N-1:0]      i_mem_rdata,
    output logic              o_dump_valid,
    input  logic              i_dump_ready,
    output logic [ADDR_W-1:0] o_dump_addr,
    output logic [N-1:0]      o_dump_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NWORDS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_READ  = 3'd2,
        S_CAPT  = 3'd3,
        S_SEND  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_dump_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_dump_addr;
    logic [N-1:0]      r_dump_data;
    logic              w_start;
    logic              w_last;

    // a start is only honoured from IDLE, so edges while busy are dropped
    assign w_start = i_dump & ~r_dump_q;
    assign w_last  = (r_idx == IDX_LAST);

    // state register
    always_ff @(posedge i_mclk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_DRAIN;
            S_DRAIN: if (r_cnt == '0) w_next = S_READ;
            S_READ:  w_next = S_CAPT;
            S_CAPT:  w_next = S_SEND;
            S_SEND:  if (i_dump_ready) w_next = w_last ? S_DONE : S_READ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // i_dump history for edge detection, sampled every cycle
    always_ff @(posedge i_mclk or posedge i_reset) begin
        if (i_reset) begin
            r_dump_q <= 1'b0;
        end else begin
            r_dump_q <= i_dump;
        end
    end

    // drain timer, word index and read address; the address register is
    // loaded only on entry to READ so it holds its last value elsewhere
    always_ff @(posedge i_mclk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt <= CNT_LOAD;
                        r_idx <= '0;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else begin
                        r_mem_addr <= r_idx;
                    end
                end
                S_SEND: begin
                    if (i_dump_ready && !w_last) begin
                        r_idx      <= r_idx + IDX_ONE;
                        r_mem_addr <= r_idx + IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // beat registers, written only in CAPT so they stay stable under backpressure
    always_ff @(posedge i_mclk or posedge i_reset) begin
        if (i_reset) begin
            r_dump_addr <= '0;
            r_dump_data <= '0;
        end else if (r_state == S_CAPT) begin
            r_dump_addr <= r_idx;
            r_dump_data <= i_mem_rdata;
        end
    end

    // Moore outputs decoded from the state register
    always_comb begin
        o_busy       = (r_state != S_IDLE);
        o_cpu_stall  = (r_state != S_IDLE);
        o_mem_re     = (r_state == S_READ);
        o_dump_valid = (r_state == S_SEND);
        o_done       = (r_state == S_DONE);
        o_mem_addr   = r_mem_addr;
        o_dump_addr  = r_dump_addr;
        o_dump_data  = r_dump_data;
    end

endmodule

// File: doc/dmem_dump_ctrl.md
DMEM_DUMP_CTRL -- requirements
Module: dmem_dump_ctrl

Interface
REQ-001 Parameter N, default 64: data word width in bits.
REQ-002 Parameter ADDR_W, default 6: data memory address width (word index).
REQ-003 Parameter NWORDS, default 64: number of words dumped; 1 <= NWORDS <= 2**ADDR_W.
REQ-004 Parameter DRAIN_CYC, default 5: cycles waited after stall assertion before the first read; >= 1.
REQ-005 i_mclk  in  1  sole clock; all state updates on the rising edge.
REQ-006 i_reset  in  1  asynchronous, active-high reset.
REQ-007 i_dump  in  1  dump request level; a rising edge starts one dump sequence.
REQ-008 o_cpu_stall  out  1  freezes processor PC and register/memory writes while high.
REQ-009 o_mem_re  out  1  data memory read enable.
REQ-010 o_mem_addr  out  ADDR_W  data memory word address.
REQ-011 i_mem_rdata  in  N  read data, valid exactly one cycle after o_mem_re.
REQ-012 o_dump_valid  out  1  dump beat valid.
REQ-013 i_dump_ready  in  1  consumer accepts beat.
REQ-014 o_dump_addr  out  ADDR_W  word index of current beat.
REQ-015 o_dump_data  out  N  word value of current beat.
REQ-016 o_busy  out  1  high in every state except IDLE.
REQ-017 o_done  out  1  one-cycle pulse at sequence completion.

Function
REQ-018 The block SHALL be a Moore FSM with states IDLE, DRAIN, READ, CAPT, SEND, DONE; all outputs derive from registers.
REQ-019 Edge detect: dump_q register holds the previous i_dump sample; start = i_dump & ~dump_q, evaluated only in IDLE.
REQ-020 IDLE: on start -> DRAIN, drain counter loaded DRAIN_CYC-1, word index idx cleared to 0.
REQ-021 DRAIN: counter decrements each cycle; at 0 -> READ (DRAIN lasts exactly DRAIN_CYC cycles).
REQ-022 READ: o_mem_re=1, o_mem_addr=idx for exactly one cycle; -> CAPT.
REQ-023 CAPT: o_dump_data <= i_mem_rdata, o_dump_addr <= idx; -> SEND.
REQ-024 SEND: o_dump_valid=1; beat transfers on an edge with i_dump_ready=1; then idx==NWORDS-1 -> DONE, else idx+1 -> READ.
REQ-025 While o_dump_valid=1 and i_dump_ready=0, o_dump_data and o_dump_addr SHALL stay stable and o_mem_re SHALL stay 0.
REQ-026 i_dump_ready outside SEND SHALL have no effect; ready asserted in the first SEND cycle transfers on that edge.
REQ-027 DONE: o_done=1 for one cycle; -> IDLE.
REQ-028 o_cpu_stall=1 in DRAIN, READ, CAPT, SEND, DONE; 0 in IDLE.
REQ-029 Minimum cost per word: 3 cycles; stall duration with ready tied high = DRAIN_CYC + 3*NWORDS + 1 cycles.
REQ-030 Rising edges of i_dump while o_busy=1 SHALL be ignored and not queued; i_dump held high through DONE does not restart until it falls and rises again.
REQ-031 o_mem_re SHALL be 0 and o_mem_addr SHALL hold its last value outside READ.
REQ-032 idx SHALL never exceed NWORDS-1; no address wrap occurs.

Reset
REQ-033 i_reset=1 SHALL immediately force state IDLE, idx=0, drain counter=0, dump_q=0, and all outputs (o_cpu_stall, o_mem_re, o_mem_addr, o_dump_valid, o_dump_addr, o_dump_data, o_busy, o_done) to 0.
REQ-034 Reset mid-sequence SHALL abort with no o_done pulse; the next dump restarts at address 0.
REQ-035 Because dump_q resets to 0, i_dump already high on the first edge after reset release SHALL start a dump.

Verification
REQ-036 Reset: assert i_reset mid-cycle with FSM in SEND -> all outputs 0 before next clock edge.
REQ-037 Full dump, DRAIN_CYC=4, NWORDS=64, mem[k]=3k, ready tied 1: stall high 197 cycles; first o_mem_re 4 cycles after stall rises; 64 beats addr 0..63, data 3k; one o_done pulse; stall low the cycle after o_done.
REQ-038 Backpressure: ready low for 5 cycles at beat 10 -> valid held, addr=10, data=30 stable, no o_mem_re; beat 11 read starts the cycle after acceptance.
REQ-039 Retrigger: second i_dump pulse during DRAIN and i_dump held high through DONE -> exactly one sequence; new sequence only after i_dump low then high.
REQ-040 Abort: reset at beat 20 then new i_dump edge -> first beat addr 0, 64 beats, single o_done.
REQ-041 Boundary NWORDS=1, DRAIN_CYC=1: one beat addr 0, stall high exactly 5 cycles.
